// File: rtl/bus_read_mux.sv
// Reader side of the processor bus: registers one selected source onto buswire.
// Memory reads use a programmable wait-state countdown; illegal selects are flagged.
module bus_read_mux #(
   parameter int WIDTH       = 16,
   parameter int MEM_LATENCY = 1
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             rd_req,
   input  logic [3:0]       rd_sel,
   input  logic [WIDTH-1:0] r0,
   input  logic [WIDTH-1:0] r1,
   input  logic [WIDTH-1:0] r2,
   input  logic [WIDTH-1:0] r3,
   input  logic [WIDTH-1:0] r4,
   input  logic [WIDTH-1:0] r5,
   input  logic [WIDTH-1:0] r6,
   input  logic [WIDTH-1:0] r7,
   input  logic [WIDTH-1:0] g_in,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] mem_data,
   output logic             mem_rd,
   output logic [WIDTH-1:0] buswire,
   output logic             bus_valid,
   output logic             busy,
   output logic             sel_err,
   output logic             req_drop
);

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] MEM_WAIT = 1'b1;
   localparam logic [3:0] LAT      = 4'(MEM_LATENCY);

   logic [0:0]       state;
   logic [3:0]       wait_cnt;
   logic [WIDTH-1:0] src;
   logic             src_ok;
   logic             is_mem;

   // Decode the direct (single-cycle) source for the current select
   always_comb begin
      src    = '0;
      src_ok = 1'b1;
      is_mem = (rd_sel == 4'd10);
      case (rd_sel)
         4'd0:    src = r0;
         4'd1:    src = r1;
         4'd2:    src = r2;
         4'd3:    src = r3;
         4'd4:    src = r4;
         4'd5:    src = r5;
         4'd6:    src = r6;
         4'd7:    src = r7;
         4'd8:    src = g_in;
         4'd9:    src = din;
         default: src_ok = 1'b0;
      endcase
   end

   // Bus register, memory wait-state FSM and one-cycle status pulses
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         buswire   <= '0;
         bus_valid <= 1'b0;
         busy      <= 1'b0;
         mem_rd    <= 1'b0;
         sel_err   <= 1'b0;
         req_drop  <= 1'b0;
      end else begin
         bus_valid <= 1'b0;
         mem_rd    <= 1'b0;
         sel_err   <= 1'b0;
         req_drop  <= 1'b0;
         case (state)
            IDLE: begin
               if (rd_req) begin
                  if (is_mem) begin
                     mem_rd   <= 1'b1;
                     busy     <= 1'b1;
                     wait_cnt <= LAT;
                     state    <= MEM_WAIT;
                  end else if (src_ok) begin
                     buswire   <= src;
                     bus_valid <= 1'b1;
                  end else begin
                     sel_err <= 1'b1;
                  end
               end
            end
            MEM_WAIT: begin
               req_drop <= rd_req;
               if (wait_cnt == 4'd1) begin
                  buswire   <= mem_data;
                  bus_valid <= 1'b1;
                  busy      <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bus_read_mux.sv
// Randomized self-checking bench for bus_read_mux.
// Reference model tracks the absolute cycle at which a memory read completes.
module tb_bus_read_mux;

   localparam int W   = 16;
   localparam int LAT = 3;

   logic         clock = 1'b0;
   logic         resetn = 1'b0;
   logic         rd_req = 1'b0;
   logic [3:0]   rd_sel = '0;
   logic [W-1:0] rr [8];
   logic [W-1:0] g_in, din, mem_data;
   logic         mem_rd, bus_valid, busy, sel_err, req_drop;
   logic [W-1:0] buswire;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [W-1:0] m_bus;
   int           m_done;

   bus_read_mux #(.WIDTH(W), .MEM_LATENCY(LAT)) dut (
      .clock(clock), .resetn(resetn),
      .rd_req(rd_req), .rd_sel(rd_sel),
      .r0(rr[0]), .r1(rr[1]), .r2(rr[2]), .r3(rr[3]),
      .r4(rr[4]), .r5(rr[5]), .r6(rr[6]), .r7(rr[7]),
      .g_in(g_in), .din(din), .mem_data(mem_data),
      .mem_rd(mem_rd), .buswire(buswire), .bus_valid(bus_valid),
      .busy(busy), .sel_err(sel_err), .req_drop(req_drop)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input logic e_v, input logic e_busy,
                            input logic e_rd, input logic e_err,
                            input logic e_drop);
      check("buswire", buswire, m_bus);
      check("bus_valid", W'(bus_valid), W'(e_v));
      check("busy", W'(busy), W'(e_busy));
      check("mem_rd", W'(mem_rd), W'(e_rd));
      check("sel_err", W'(sel_err), W'(e_err));
      check("req_drop", W'(req_drop), W'(e_drop));
   endtask

   task automatic rand_data();
      for (int i = 0; i < 8; i++) rr[i] = W'($urandom);
      g_in     = W'($urandom);
      din      = W'($urandom);
      mem_data = W'($urandom);
   endtask

   // One clock: apply request, predict outcome, compare after the edge
   task automatic step(input logic req, input logic [3:0] sel);
      int   n;
      logic e_v, e_rd, e_err, e_drop;
      rd_req = req;
      rd_sel = sel;
      n      = cyc + 1;
      e_v    = 1'b0;
      e_rd   = 1'b0;
      e_err  = 1'b0;
      e_drop = 1'b0;
      if (m_done >= 0) begin
         e_drop = req;
         if (n == m_done) begin
            m_bus  = mem_data;
            e_v    = 1'b1;
            m_done = -1;
         end
      end else if (req) begin
         if (sel < 4'd8) begin
            m_bus = rr[sel[2:0]];
            e_v   = 1'b1;
         end else if (sel == 4'd8) begin
            m_bus = g_in;
            e_v   = 1'b1;
         end else if (sel == 4'd9) begin
            m_bus = din;
            e_v   = 1'b1;
         end else if (sel == 4'd10) begin
            e_rd   = 1'b1;
            m_done = n + LAT;
         end else begin
            e_err = 1'b1;
         end
      end
      @(posedge clock);
      #1;
      check_all(e_v, m_done >= 0, e_rd, e_err, e_drop);
   endtask

   // Asynchronous reset between clock edges
   task automatic do_reset();
      rd_req = 1'b0;
      resetn = 1'b0;
      #1;
      m_bus  = '0;
      m_done = -1;
      check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clock);
      #2;
      resetn = 1'b1;
   endtask

   initial begin
      rand_data();
      m_bus  = '0;
      m_done = -1;
      repeat (2) @(posedge clock);
      #1;
      check_all(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      resetn = 1'b1;

      rr[3] = 16'h1234;
      step(1'b1, 4'd3);
      check("r3_value", buswire, 16'h1234);
      step(1'b0, 4'd0);
      check("r3_hold", buswire, 16'h1234);

      g_in = 16'hBEEF;
      step(1'b1, 4'd8);
      check("g_value", buswire, 16'hBEEF);
      din = 16'h00FF;
      step(1'b1, 4'd9);
      check("din_value", buswire, 16'h00FF);

      mem_data = 16'hA5A5;
      step(1'b1, 4'd10);
      step(1'b1, 4'd2);
      step(1'b0, 4'd0);
      step(1'b0, 4'd0);
      check("mem_value", buswire, 16'hA5A5);

      step(1'b1, 4'd13);
      check("illegal_hold", buswire, 16'hA5A5);

      step(1'b1, 4'd5);
      do_reset();
      step(1'b0, 4'd0);

      step(1'b1, 4'd10);
      step(1'b0, 4'd0);
      do_reset();
      repeat (6) step(1'b0, 4'd0);
      check("abandoned_read", buswire, 16'h0000);

      repeat (400) begin
         rand_data();
         if ($urandom_range(0, 99) == 0) do_reset();
         else step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
